mesh_torus_link_pipe: RTL and testbench
=======================================

// Module: mesh_torus_link_pipe
// PURPOSE
// - Parametrised router-to-router link for mesh/torus/fmesh/ring/line NoCs.
// - Carries a flit + VC id from the upstream router output port to the downstream router input port.
// - Registered forward path; registered credit-return path.
// - Extra stages on torus/ring wrap-around (long) links.
// - Per-VC outstanding-credit monitor with sticky error flags.
// - Sits between the router_chan_out and router_chan_in pairs wired by the NoC top.
// PARAMETERS
// - FLIT_W      32  flit payload width (bits)
// - V           2   virtual channels per port; VC fields are one-hot, V bits
// - B           4   downstream buffer depth per VC (flits) = initial credit per VC
// - FWD_STAGES  1   forward register stages (0 = combinational)
// - BWD_STAGES  1   credit-return register stages (0 = combinational)
// - IS_WRAP     0   1 = wrap-around link; adds WRAP_EXTRA stages to both paths
// - WRAP_EXTRA  2   additional stages applied when IS_WRAP=1
// PORTS
// - clk            in   1       clock
// - reset          in   1       synchronous, active-high reset
// - up_flit_wr     in   1       upstream flit valid
// - up_flit        in   FLIT_W  upstream flit
// - up_vc          in   V       upstream flit VC, one-hot
// - up_credit_out  out  V       credit pulses returned to upstream
// - dn_flit_wr     out  1       downstream flit valid
// - dn_flit        out  FLIT_W  downstream flit
// - dn_vc          out  V       downstream flit VC, one-hot
// - dn_credit_in   in   V       credit pulses from downstream
// - outstanding    out  V*CW    per-VC in-flight count; CW=$clog2(B+1); VC i at [i*CW +: CW]
// - credit_err     out  V       sticky: overflow/underflow per VC
// - flit_count     out  32      forwarded-flit counter (see CONFIGURATION)
// BEHAVIOUR
// - Effective depths:
//   - FS = FWD_STAGES + (IS_WRAP ? WRAP_EXTRA : 0)
//   - BS = BWD_STAGES + (IS_WRAP ? WRAP_EXTRA : 0)
// - Forward path:
//   - up_{flit_wr,flit,vc} sampled at edge k appears on dn_* at edge k+FS.
//   - FS=0: pure wires, same cycle.
//   - No stall or backpressure; one flit per cycle max; flow control is credit-only.
// - Credit path: dn_credit_in bits at edge k appear on up_credit_out at edge k+BS.
//   - Multiple VC bits may be set in one cycle.
// - Stage registers:
//   - Valid and VC bits reset to 0.
//   - Flit payload is not reset (don't-care while valid=0).
// - Reset values:
//   - dn_flit_wr=0, dn_vc=0, up_credit_out=0.
//   - outstanding=0, credit_err=0, flit_count=0.
// - Monitor counter O[i], updated at the upstream side, each cycle:
//   - inc = up_flit_wr & up_vc[i]; dec = up_credit_out[i].
//   - inc & dec: O unchanged.
//   - inc only, O==B: O held, credit_err[i] set (overflow).
//   - dec only, O==0: O held, credit_err[i] set (underflow).
//   - otherwise: O +1 / -1.
// - credit_err bits: sticky until reset.
// - Any up_flit_wr=1 with up_vc not exactly one-hot (zero or multiple bits) sets all credit_err bits.
//   - The flit is still forwarded unchanged.
// - Reset mid-operation:
//   - All in-flight flits and credits in the stage registers are discarded.
//   - Counters clear.
//   - Both routers are reset by the same reset, so credits re-initialise to B.
// - Round-trip latency seen by upstream = FS + BS + router credit delay.
//   - Integrators size B against this.
// CONFIGURATION
// - Macro: MESH_TORUS_LINK_STATS_EN.
// - Defined:
//   - flit_count increments by 1 on every cycle with dn_flit_wr=1.
//   - Saturates at 32'hFFFF_FFFF.
//   - Synchronously cleared by reset.
// - Undefined:
//   - flit_count tied to 32'd0; no counter logic synthesised.
//   - All other behaviour identical.
// TESTING
// 1. Latency: FWD_STAGES=1, IS_WRAP=0.
//    - up_flit_wr=1, up_flit=32'hA5A5_0001, up_vc=2'b01 at cycle 10.
//    - -> dn_flit_wr=1, dn_flit=32'hA5A5_0001, dn_vc=2'b01 at cycle 11; dn_flit_wr=0 at cycle 12.
// 2. Wrap latency: IS_WRAP=1, WRAP_EXTRA=2, BWD_STAGES=1.
//    - dn_credit_in=2'b10 at cycle 5 -> up_credit_out=2'b10 at cycle 8 only.
//    - Forward path on the same link delays by 3.
// 3. Back-to-back stream: 8 consecutive flits, alternating VC.
//    - -> same 8 flits, same order, no gaps, on dn_* after FS cycles.
//    - With STATS_EN: flit_count=8.
// 4. Overflow: B=4, send 5 flits on VC0 with no credits.
//    - -> outstanding[VC0]=4 after flit 4; credit_err=2'b01 after flit 5.
//    - credit_err stays set after 3 credits return.
// 5. Simultaneous events: O[VC1]=2; flit on VC1 and up_credit_out[1] in the same cycle.
//    - -> O[VC1]=2, credit_err=0.
//    - Credit at O=0 -> credit_err[1]=1.
// 6. Reset mid-flight: FS=3, 3 flits in pipe, assert reset 1 cycle.
//    - -> dn_flit_wr=0 for the next 3 cycles.
//    - outstanding=0, credit_err=0, flit_count=0.

Source files
------------

// File: rtl/mesh_torus_link_pipe.sv
// Router-to-router NoC link: staged flit/credit paths plus a per-VC outstanding-credit monitor.
// Defining MESH_TORUS_LINK_STATS_EN adds a saturating forwarded-flit counter on flit_count.
module mesh_torus_link_pipe #(
    parameter int FLIT_W     = 32,
    parameter int V          = 2,
    parameter int B          = 4,
    parameter int FWD_STAGES = 1,
    parameter int BWD_STAGES = 1,
    parameter int IS_WRAP    = 0,
    parameter int WRAP_EXTRA = 2,
    localparam int CW        = $clog2(B + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_flit_wr,
    input  logic [FLIT_W-1:0] up_flit,
    input  logic [V-1:0]      up_vc,
    output logic [V-1:0]      up_credit_out,
    output logic              dn_flit_wr,
    output logic [FLIT_W-1:0] dn_flit,
    output logic [V-1:0]      dn_vc,
    input  logic [V-1:0]      dn_credit_in,
    output logic [V*CW-1:0]   outstanding,
    output logic [V-1:0]      credit_err,
    output logic [31:0]       flit_count
);

    localparam int FS = FWD_STAGES + ((IS_WRAP != 0) ? WRAP_EXTRA : 0);
    localparam int BS = BWD_STAGES + ((IS_WRAP != 0) ? WRAP_EXTRA : 0);

    generate
        if (FS == 0) begin : g_fwd_comb
            assign dn_flit_wr = up_flit_wr;
            assign dn_flit    = up_flit;
            assign dn_vc      = up_vc;
        end else begin : g_fwd_pipe
            logic [FS-1:0]     vld_q;
            logic [V-1:0]      vc_q   [FS];
            logic [FLIT_W-1:0] flit_q [FS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int s = 0; s < FS; s++) vc_q[s] <= '0;
                end else begin
                    vld_q[0] <= up_flit_wr;
                    vc_q[0]  <= up_vc;
                    for (int s = 1; s < FS; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        vc_q[s]  <= vc_q[s-1];
                    end
                end
            end

            // Payload is qualified by the valid bit, so it needs no reset.
            always_ff @(posedge clk) begin
                flit_q[0] <= up_flit;
                for (int s = 1; s < FS; s++) flit_q[s] <= flit_q[s-1];
            end

            assign dn_flit_wr = vld_q[FS-1];
            assign dn_flit    = flit_q[FS-1];
            assign dn_vc      = vc_q[FS-1];
        end

        if (BS == 0) begin : g_bwd_comb
            assign up_credit_out = dn_credit_in;
        end else begin : g_bwd_pipe
            logic [V-1:0] crd_q [BS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < BS; s++) crd_q[s] <= '0;
                end else begin
                    crd_q[0] <= dn_credit_in;
                    for (int s = 1; s < BS; s++) crd_q[s] <= crd_q[s-1];
                end
            end

            assign up_credit_out = crd_q[BS-1];
        end
    endgenerate

    logic [CW-1:0] cnt_q [V];
    logic [CW-1:0] cnt_d [V];
    logic [V-1:0]  err_q;
    logic [V-1:0]  err_d;
    logic          vc_bad;

    assign vc_bad = up_flit_wr && !$onehot(up_vc);

    // Counters hold at their limits; the sticky error bit records the attempt.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | {V{vc_bad}};
        for (int i = 0; i < V; i++) begin
            if (up_flit_wr && up_vc[i] && !up_credit_out[i]) begin
                if (cnt_q[i] == CW'(B)) err_d[i] = 1'b1;
                else                    cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!(up_flit_wr && up_vc[i]) && up_credit_out[i]) begin
                if (cnt_q[i] == '0) err_d[i] = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) cnt_q[i] <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    generate
        for (genvar g = 0; g < V; g++) begin : g_out
            assign outstanding[g*CW +: CW] = cnt_q[g];
        end
    endgenerate

    assign credit_err = err_q;

`ifdef MESH_TORUS_LINK_STATS_EN
    logic [31:0] fcnt_q;
    logic [31:0] fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if (dn_flit_wr && (fcnt_q != 32'hFFFF_FFFF)) fcnt_d = fcnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) fcnt_q <= '0;
        else       fcnt_q <= fcnt_d;
    end

    assign flit_count = fcnt_q;
`else
    assign flit_count = 32'd0;
`endif

endmodule

// File: tb/tb_mesh_torus_link_pipe.sv
// Directed bench for mesh_torus_link_pipe: a plain link (FS=BS=1) and a wrap link (FS=BS=3).
module tb_mesh_torus_link_pipe;

    logic        clk = 1'b0;
    logic        a_reset, a_up_flit_wr, a_dn_flit_wr;
    logic [31:0] a_up_flit, a_dn_flit, a_flit_count;
    logic [1:0]  a_up_vc, a_dn_vc, a_up_credit_out, a_dn_credit_in, a_credit_err;
    logic [5:0]  a_outstanding;

    logic        w_reset, w_up_flit_wr, w_dn_flit_wr;
    logic [31:0] w_up_flit, w_dn_flit, w_flit_count;
    logic [1:0]  w_up_vc, w_dn_vc, w_up_credit_out, w_dn_credit_in, w_credit_err;
    logic [5:0]  w_outstanding;

    int passCount = 0;
    int failCount = 0;
    int total     = 0;
    logic [31:0] expCount8;

    always #5 clk = ~clk;

    mesh_torus_link_pipe dutA (
        .clk(clk), .reset(a_reset),
        .up_flit_wr(a_up_flit_wr), .up_flit(a_up_flit), .up_vc(a_up_vc),
        .up_credit_out(a_up_credit_out),
        .dn_flit_wr(a_dn_flit_wr), .dn_flit(a_dn_flit), .dn_vc(a_dn_vc),
        .dn_credit_in(a_dn_credit_in),
        .outstanding(a_outstanding), .credit_err(a_credit_err), .flit_count(a_flit_count)
    );

    mesh_torus_link_pipe #(.IS_WRAP(1), .WRAP_EXTRA(2)) dutW (
        .clk(clk), .reset(w_reset),
        .up_flit_wr(w_up_flit_wr), .up_flit(w_up_flit), .up_vc(w_up_vc),
        .up_credit_out(w_up_credit_out),
        .dn_flit_wr(w_dn_flit_wr), .dn_flit(w_dn_flit), .dn_vc(w_dn_vc),
        .dn_credit_in(w_dn_credit_in),
        .outstanding(w_outstanding), .credit_err(w_credit_err), .flit_count(w_flit_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the plain link, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] flit,
                                 input logic [1:0] vc, input logic [1:0] cr);
        a_up_flit_wr = wr; a_up_flit = flit; a_up_vc = vc; a_dn_credit_in = cr;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulusW(input logic wr, input logic [31:0] flit,
                                  input logic [1:0] vc, input logic [1:0] cr);
        w_up_flit_wr = wr; w_up_flit = flit; w_up_vc = vc; w_dn_credit_in = cr;
        @(posedge clk); #1;
    endtask

    task automatic resetA();
        a_reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        a_reset = 1'b0;
    endtask

    task automatic resetW();
        w_reset = 1'b1;
        applyStimulusW(1'b0, 32'd0, 2'b00, 2'b00);
        w_reset = 1'b0;
    endtask

    initial begin
`ifdef MESH_TORUS_LINK_STATS_EN
        expCount8 = 32'd8;
`else
        expCount8 = 32'd0;
`endif
        a_reset = 1'b1; w_reset = 1'b1;
        a_up_flit_wr = 0; a_up_flit = 0; a_up_vc = 0; a_dn_credit_in = 0;
        w_up_flit_wr = 0; w_up_flit = 0; w_up_vc = 0; w_dn_credit_in = 0;
        repeat (2) @(posedge clk);
        #1;
        a_reset = 1'b0; w_reset = 1'b0;

        checkOutput("rst_dn_flit_wr", a_dn_flit_wr, 0);
        checkOutput("rst_dn_vc", a_dn_vc, 0);
        checkOutput("rst_up_credit", a_up_credit_out, 0);
        checkOutput("rst_outstanding", a_outstanding, 0);
        checkOutput("rst_credit_err", a_credit_err, 0);
        checkOutput("rst_flit_count", a_flit_count, 0);
        checkOutput("rst_w_dn_flit_wr", w_dn_flit_wr, 0);

        applyStimulus(1'b1, 32'hA5A5_0001, 2'b01, 2'b00);
        checkOutput("lat_dn_flit_wr", a_dn_flit_wr, 1);
        checkOutput("lat_dn_flit", a_dn_flit, 32'hA5A5_0001);
        checkOutput("lat_dn_vc", a_dn_vc, 2'b01);
        applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("lat_dn_flit_wr_off", a_dn_flit_wr, 0);
        checkOutput("lat_outstanding", a_outstanding, 6'b000_001);
        applyStimulus(1'b0, 32'd0, 2'b00, 2'b01);
        checkOutput("crd_up_credit", a_up_credit_out, 2'b01);
        checkOutput("crd_outstanding_hold", a_outstanding, 6'b000_001);
        applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("crd_up_credit_off", a_up_credit_out, 2'b00);
        checkOutput("crd_outstanding_dec", a_outstanding, 6'b000_000);

        resetA();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h1000_0000 + i, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
            checkOutput($sformatf("b2b_wr_%0d", i), a_dn_flit_wr, 1);
            checkOutput($sformatf("b2b_flit_%0d", i), a_dn_flit, 32'h1000_0000 + i);
            checkOutput($sformatf("b2b_vc_%0d", i), a_dn_vc, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("b2b_drained", a_dn_flit_wr, 0);
        checkOutput("b2b_outstanding", a_outstanding, 6'b100_100);
        checkOutput("b2b_credit_err", a_credit_err, 2'b00);
        repeat (4) applyStimulus(1'b0, 32'd0, 2'b00, 2'b11);
        repeat (2) applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("b2b_outstanding_ret", a_outstanding, 6'b000_000);
        checkOutput("b2b_flit_count", a_flit_count, expCount8);

        resetA();
        repeat (4) applyStimulus(1'b1, 32'h0000_0B0B, 2'b01, 2'b00);
        checkOutput("ovf_outstanding_full", a_outstanding, 6'b000_100);
        checkOutput("ovf_err_before", a_credit_err, 2'b00);
        applyStimulus(1'b1, 32'h0000_0B0B, 2'b01, 2'b00);
        checkOutput("ovf_outstanding_held", a_outstanding, 6'b000_100);
        checkOutput("ovf_err_set", a_credit_err, 2'b01);
        repeat (3) applyStimulus(1'b0, 32'd0, 2'b00, 2'b01);
        repeat (2) applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("ovf_outstanding_ret", a_outstanding, 6'b000_001);
        checkOutput("ovf_err_sticky", a_credit_err, 2'b01);

        resetA();
        checkOutput("rst_err_cleared", a_credit_err, 2'b00);
        repeat (2) applyStimulus(1'b1, 32'h0000_0C0C, 2'b10, 2'b00);
        checkOutput("sim_outstanding_2", a_outstanding, 6'b010_000);
        applyStimulus(1'b0, 32'd0, 2'b00, 2'b10);
        checkOutput("sim_credit_vis", a_up_credit_out, 2'b10);
        applyStimulus(1'b1, 32'h0000_0C0D, 2'b10, 2'b00);
        checkOutput("sim_outstanding_same", a_outstanding, 6'b010_000);
        checkOutput("sim_err_clear", a_credit_err, 2'b00);
        repeat (3) applyStimulus(1'b0, 32'd0, 2'b00, 2'b10);
        repeat (2) applyStimulus(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("udf_outstanding", a_outstanding, 6'b000_000);
        checkOutput("udf_err", a_credit_err, 2'b10);

        resetA();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b11, 2'b00);
        checkOutput("vc2_err", a_credit_err, 2'b11);
        checkOutput("vc2_dn_vc", a_dn_vc, 2'b11);
        checkOutput("vc2_dn_flit", a_dn_flit, 32'hDEAD_BEEF);
        resetA();
        applyStimulus(1'b1, 32'h0000_1234, 2'b00, 2'b00);
        checkOutput("vc0_err", a_credit_err, 2'b11);
        checkOutput("vc0_dn_wr", a_dn_flit_wr, 1);
        checkOutput("vc0_dn_vc", a_dn_vc, 2'b00);
        resetA();

        applyStimulusW(1'b0, 32'd0, 2'b00, 2'b10);
        checkOutput("wrap_crd_c6", w_up_credit_out, 2'b00);
        applyStimulusW(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("wrap_crd_c7", w_up_credit_out, 2'b00);
        applyStimulusW(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("wrap_crd_c8", w_up_credit_out, 2'b10);
        applyStimulusW(1'b0, 32'd0, 2'b00, 2'b00);
        checkOutput("wrap_crd_c9", w_up_credit_out, 2'b00);
        checkOutput("wrap_udf_err", w_credit_err, 2'b10);

        resetW();
        applyStimulusW(1'b1, 32'h0000_F000, 2'b01, 2'b00);
        checkOutput("wrap_fwd_c1", w_dn_flit_wr, 0);
        applyStimulusW(1'b1, 32'h0000_F001, 2'b01, 2'b00);
        checkOutput("wrap_fwd_c2", w_dn_flit_wr, 0);
        applyStimulusW(1'b1, 32'h0000_F002, 2'b01, 2'b00);
        checkOutput("wrap_fwd_wr", w_dn_flit_wr, 1);
        checkOutput("wrap_fwd_flit", w_dn_flit, 32'h0000_F000);
        checkOutput("wrap_fwd_vc", w_dn_vc, 2'b01);
        checkOutput("wrap_outstanding", w_outstanding, 6'b000_011);
        resetW();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("midrst_dn_wr_%0d", i), w_dn_flit_wr, 0);
            applyStimulusW(1'b0, 32'd0, 2'b00, 2'b00);
        end
        checkOutput("midrst_outstanding", w_outstanding, 0);
        checkOutput("midrst_credit_err", w_credit_err, 0);
        checkOutput("midrst_flit_count", w_flit_count, 0);

        $display("%0d/%0d checks passed", passCount, total);
        $finish;
    end

endmodule
